// File: rtl/stage4_mem_hs_if.sv
// stage4_mem_hs_if: data-memory request/acknowledge bus between the memory stage (master) and memory (slave)
interface stage4_mem_hs_if #(parameter int XLEN = 32);
    logic              mem_req_out;
    logic              mem_we_out;
    logic [XLEN-1:0]   mem_addr_out;
    logic [XLEN-1:0]   mem_wdata_out;
    logic [XLEN/8-1:0] mem_wstrb_out;
    logic [XLEN-1:0]   mem_rdata_in;
    logic              mem_ack_in;
    modport master (output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wstrb_out,
                    input mem_rdata_in, mem_ack_in);
    modport slave (input mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wstrb_out,
                   output mem_rdata_in, mem_ack_in);
endinterface

// File: rtl/stage4_mem_hs.sv
// stage4_mem_hs: pipeline memory stage with sub-word access, variable-latency handshake, timeout; STAGE4_MEM_MISALIGN_TRAP_EN traps misalignment
module stage4_mem_hs #(
    parameter int XLEN           = 32,
    parameter int REG_IDX_W      = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [XLEN-1:0]      alu_res,
    input  logic [XLEN-1:0]      rs2_val,
    input  logic [REG_IDX_W-1:0] rd_idx,
    input  logic [2:0]           funct3,
    input  logic                 mem_load_enable,
    input  logic                 mem_store_enable,
    input  logic                 reg_write_enable,
    output logic                 stall_out,
    output logic                 write_enable_out,
    output logic [REG_IDX_W-1:0] write_idx_out,
    output logic [XLEN-1:0]      write_data_out,
    output logic                 bus_err_out,
    stage4_mem_hs_if.master      bus
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_d;
    logic req_q, req_d, we_q, we_d, wen_d, err_d, ld_q, ld_d, rwe_q, rwe_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, wdat_d, ld_data, sh, addr, wdata;
    logic [NB-1:0] wstrb_q, wstrb_d, wstrb;
    logic [REG_IDX_W-1:0] widx_d, rd_q, rd_d;
    logic [2:0] f3_q, f3_d, amask;
    logic [OW-1:0] off_q, off_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0] smask;
    logic [1:0] sz;
    logic mem_op, is_ld, legal, err, tmo;
    assign bus.mem_req_out   = req_q;
    assign bus.mem_we_out    = we_q;
    assign bus.mem_addr_out  = addr_q;
    assign bus.mem_wdata_out = wdata_q;
    assign bus.mem_wstrb_out = wstrb_q;
    assign mem_op    = valid_in && (mem_load_enable || mem_store_enable);
    assign is_ld     = mem_load_enable;
    assign stall_out = state == BUSY || mem_op;
    assign sz        = funct3[1:0];
    assign amask     = {sz == 2'd3, sz[1], |sz};
    assign smask     = {{4{sz == 2'd3}}, {2{sz[1]}}, |sz, 1'b1};
    assign legal     = funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                       (XLEN == 64 && funct3 == 3'b011) ||
                       (is_ld && (funct3 == 3'b100 || funct3 == 3'b101));
`ifdef STAGE4_MEM_MISALIGN_TRAP_EN
    assign addr = alu_res;
    assign err  = !legal || |(alu_res[2:0] & amask);
`else
    assign addr = alu_res & ~{{XLEN-3{1'b0}}, amask};
    assign err  = !legal;
`endif
    // Store bytes are replicated so every lane the strobe may select carries the data.
    assign wdata = sz == 2'd0 ? {NB{rs2_val[7:0]}} : sz == 2'd1 ? {NB/2{rs2_val[15:0]}} :
                   sz == 2'd2 ? {XLEN/32{rs2_val[31:0]}} : rs2_val;
    assign wstrb = NB'(smask) << addr[OW-1:0];
    assign sh    = bus.mem_rdata_in >> {off_q, 3'b000};
    assign ld_data = f3_q[1:0] == 2'd0 ? (f3_q[2] ? XLEN'(sh[7:0]) : XLEN'(signed'(sh[7:0]))) :
                     f3_q[1:0] == 2'd1 ? (f3_q[2] ? XLEN'(sh[15:0]) : XLEN'(signed'(sh[15:0]))) :
                     f3_q[1:0] == 2'd2 ? XLEN'(signed'(sh[31:0])) : sh;
    assign tmo = TIMEOUT_CYCLES != 0 && 32'(cnt_q) == TIMEOUT_CYCLES - 1;
    always_comb begin
        state_d = state;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        wen_d   = 1'b0;
        widx_d  = write_idx_out;
        wdat_d  = write_data_out;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        ld_d    = ld_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rd_d    = rd_q;
        rwe_d   = rwe_q;
        if (state == IDLE) begin
            if (mem_op && !err) begin
                state_d = BUSY;
                req_d   = 1'b1;
                we_d    = !is_ld;
                addr_d  = {alu_res[XLEN-1:OW], OW'(0)};
                wdata_d = wdata;
                wstrb_d = is_ld ? '0 : wstrb;
                cnt_d   = '0;
                ld_d    = is_ld;
                f3_d    = funct3;
                off_d   = addr[OW-1:0];
                rd_d    = rd_idx;
                rwe_d   = reg_write_enable;
            end else if (mem_op) begin
                err_d = 1'b1;
            end else if (valid_in) begin
                wen_d  = reg_write_enable;
                widx_d = rd_idx;
                wdat_d = alu_res;
            end
        end else if (bus.mem_ack_in) begin
            state_d = IDLE;
            req_d   = 1'b0;
            wen_d   = ld_q && rwe_q;
            widx_d  = ld_q ? rd_q : write_idx_out;
            wdat_d  = ld_q ? ld_data : write_data_out;
        end else if (tmo) begin
            state_d = IDLE;
            req_d   = 1'b0;
            err_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            req_q            <= 1'b0;
            we_q             <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            wstrb_q          <= '0;
            write_enable_out <= 1'b0;
            write_idx_out    <= '0;
            write_data_out   <= '0;
            bus_err_out      <= 1'b0;
            cnt_q            <= '0;
            ld_q             <= 1'b0;
            f3_q             <= '0;
            off_q            <= '0;
            rd_q             <= '0;
            rwe_q            <= 1'b0;
        end else begin
            state            <= state_d;
            req_q            <= req_d;
            we_q             <= we_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            wstrb_q          <= wstrb_d;
            write_enable_out <= wen_d;
            write_idx_out    <= widx_d;
            write_data_out   <= wdat_d;
            bus_err_out      <= err_d;
            cnt_q            <= cnt_d;
            ld_q             <= ld_d;
            f3_q             <= f3_d;
            off_q            <= off_d;
            rd_q             <= rd_d;
            rwe_q            <= rwe_d;
        end
    end
endmodule

// File: tb/tb_stage4_mem_hs.sv
// tb_stage4_mem_hs: randomized self-checking bench for stage4_mem_hs (XLEN=32, 4-cycle timeout)
module tb_stage4_mem_hs;
    localparam int XLEN = 32;
    logic clk = 0, rst_n = 0;
    logic valid_in = 0, mem_load_enable = 0, mem_store_enable = 0, reg_write_enable = 0;
    logic [31:0] alu_res = 0, rs2_val = 0;
    logic [4:0] rd_idx = 0;
    logic [2:0] funct3 = 0;
    logic stall_out, write_enable_out, bus_err_out;
    logic [4:0] write_idx_out;
    logic [31:0] write_data_out;
    int checks = 0, failures = 0;

    stage4_mem_hs_if #(.XLEN(XLEN)) bus ();

    stage4_mem_hs #(.XLEN(XLEN), .REG_IDX_W(5), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_res(alu_res), .rs2_val(rs2_val),
        .rd_idx(rd_idx), .funct3(funct3), .mem_load_enable(mem_load_enable),
        .mem_store_enable(mem_store_enable), .reg_write_enable(reg_write_enable),
        .stall_out(stall_out), .write_enable_out(write_enable_out), .write_idx_out(write_idx_out),
        .write_data_out(write_data_out), .bus_err_out(bus_err_out), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: byte-level view of the access rules.
    function automatic logic [31:0] eff_addr(logic [31:0] a, logic [2:0] f);
        int n = 1 << f[1:0];
`ifdef STAGE4_MEM_MISALIGN_TRAP_EN
        return a;
`else
        return a - (a % n);
`endif
    endfunction

    function automatic logic [31:0] exp_load(logic [31:0] d, logic [31:0] a, logic [2:0] f);
        int n = 1 << f[1:0];
        int off = eff_addr(a, f) % 4;
        logic [63:0] lim = 64'd1 << (8 * n);
        logic [63:0] v = ({32'd0, d} >> (8 * off)) % lim;
        if (!f[2] && v >= lim / 2) v = v + (64'hFFFF_FFFF_FFFF_FFFF - lim + 1);
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_strb(logic [31:0] a, logic [2:0] f);
        int n = 1 << f[1:0];
        int off = eff_addr(a, f) % 4;
        logic [3:0] s = 0;
        for (int i = 0; i < n; i++) s[off + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] exp_wdata(logic [31:0] r, logic [2:0] f);
        int n = 1 << f[1:0];
        logic [31:0] w = 0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = r[8*(i % n) +: 8];
        return w;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        valid_in = 0;
        mem_load_enable = 0;
        mem_store_enable = 0;
        reg_write_enable = 0;
        bus.mem_ack_in = 0;
    endtask

    task automatic test_reset;
        idle_in();
        rst_n = 0;
        tick();
        tick();
        checks++;
        if ({write_enable_out, bus_err_out, bus.mem_req_out, bus.mem_we_out, stall_out} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00000", {write_enable_out, bus_err_out, bus.mem_req_out, bus.mem_we_out, stall_out});
        end
        checks++;
        if ({write_data_out, bus.mem_addr_out, bus.mem_wstrb_out, write_idx_out} !== '0) begin
            failures++;
            $display("FAIL reset_data wdata=%h addr=%h strb=%b idx=%0d want all zero", write_data_out, bus.mem_addr_out, bus.mem_wstrb_out, write_idx_out);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_passthrough;
        logic [31:0] d;
        logic [4:0] r;
        logic we;
        for (int i = 0; i < 9; i++) begin
            d = i == 0 ? 32'h1234 : $urandom;
            r = i == 0 ? 5'd5 : 5'($urandom);
            we = i == 0 ? 1'b1 : 1'($urandom);
            valid_in = 1;
            alu_res = d;
            rd_idx = r;
            reg_write_enable = we;
            #1;
            checks++;
            if (stall_out !== 1'b0) begin
                failures++;
                $display("FAIL pass_stall got=%b want=0", stall_out);
            end
            tick();
            checks++;
            if (write_enable_out !== we || write_idx_out !== r || write_data_out !== d) begin
                failures++;
                $display("FAIL pass_wb got we=%b idx=%0d data=%h want we=%b idx=%0d data=%h", write_enable_out, write_idx_out, write_data_out, we, r, d);
            end
        end
        valid_in = 0;
        alu_res = $urandom;
        rd_idx = 5'($urandom);
        reg_write_enable = 1;
        tick();
        checks++;
        if (write_enable_out !== 1'b0 || write_idx_out !== r || write_data_out !== d) begin
            failures++;
            $display("FAIL bubble_hold got we=%b idx=%0d data=%h want we=0 idx=%0d data=%h", write_enable_out, write_idx_out, write_data_out, r, d);
        end
        idle_in();
    endtask

    task automatic test_load;
        logic [31:0] a, d;
        logic [2:0] f;
        logic [4:0] r;
        int w, n;
        logic [2:0] fl [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 14; i++) begin
            if (i == 0) begin a = 32'h103; f = 3'd0; d = 32'h80FF_FF00; w = 3; end
            else if (i == 1) begin a = 32'h102; f = 3'd5; d = 32'hBEEF_0000; w = 0; end
            else begin
                f = fl[$urandom_range(0, 4)];
                n = 1 << f[1:0];
                a = ($urandom & 32'hFFFF_FFF0) + 32'($urandom_range(0, 4 / n - 1) * n);
                d = $urandom;
                w = $urandom_range(0, 2);
            end
            r = 5'($urandom_range(1, 31));
            valid_in = 1; mem_load_enable = 1; reg_write_enable = 1;
            alu_res = a; funct3 = f; rd_idx = r;
            #1;
            checks++;
            if (stall_out !== 1'b1) begin
                failures++;
                $display("FAIL ld_accept_stall got=%b want=1", stall_out);
            end
            tick();
            idle_in();
            checks++;
            if (bus.mem_req_out !== 1'b1 || bus.mem_we_out !== 1'b0 || write_enable_out !== 1'b0 || bus.mem_addr_out !== (a & ~32'd3)) begin
                failures++;
                $display("FAIL ld_req got req=%b we=%b wen=%b addr=%h want req=1 we=0 wen=0 addr=%h", bus.mem_req_out, bus.mem_we_out, write_enable_out, bus.mem_addr_out, a & ~32'd3);
            end
            for (int k = 0; k < w; k++) begin
                tick();
                checks++;
                if (bus.mem_req_out !== 1'b1 || stall_out !== 1'b1 || bus.mem_addr_out !== (a & ~32'd3)) begin
                    failures++;
                    $display("FAIL ld_wait got req=%b stall=%b addr=%h want req=1 stall=1 addr=%h", bus.mem_req_out, stall_out, bus.mem_addr_out, a & ~32'd3);
                end
            end
            bus.mem_ack_in = 1;
            bus.mem_rdata_in = d;
            tick();
            bus.mem_ack_in = 0;
            bus.mem_rdata_in = $urandom;
            checks++;
            if (bus.mem_req_out !== 1'b0 || stall_out !== 1'b0 || bus_err_out !== 1'b0) begin
                failures++;
                $display("FAIL ld_done_ctrl got req=%b stall=%b err=%b want 0 0 0", bus.mem_req_out, stall_out, bus_err_out);
            end
            checks++;
            if (write_enable_out !== 1'b1 || write_idx_out !== r || write_data_out !== exp_load(d, a, f)) begin
                failures++;
                $display("FAIL ld_data f3=%0d addr=%h rdata=%h got we=%b idx=%0d data=%h want we=1 idx=%0d data=%h", f, a, d, write_enable_out, write_idx_out, write_data_out, r, exp_load(d, a, f));
            end
        end
    endtask

    task automatic test_store;
        logic [31:0] a, s;
        logic [2:0] f;
        int w, n;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin a = 32'h202; f = 3'd1; s = 32'hAAAA_5678; w = 1; end
            else begin
                f = 3'($urandom_range(0, 2));
                n = 1 << f[1:0];
                a = ($urandom & 32'hFFFF_FFF0) + 32'($urandom_range(0, 4 / n - 1) * n);
                s = $urandom;
                w = $urandom_range(0, 2);
            end
            valid_in = 1; mem_store_enable = 1; reg_write_enable = 1;
            alu_res = a; funct3 = f; rs2_val = s; rd_idx = 5'd7;
            tick();
            idle_in();
            checks++;
            if (bus.mem_req_out !== 1'b1 || bus.mem_we_out !== 1'b1 || bus.mem_addr_out !== (a & ~32'd3)) begin
                failures++;
                $display("FAIL st_req got req=%b we=%b addr=%h want req=1 we=1 addr=%h", bus.mem_req_out, bus.mem_we_out, bus.mem_addr_out, a & ~32'd3);
            end
            checks++;
            if (bus.mem_wstrb_out !== exp_strb(a, f) || bus.mem_wdata_out !== exp_wdata(s, f)) begin
                failures++;
                $display("FAIL st_lanes f3=%0d addr=%h got strb=%b wdata=%h want strb=%b wdata=%h", f, a, bus.mem_wstrb_out, bus.mem_wdata_out, exp_strb(a, f), exp_wdata(s, f));
            end
            repeat (w) tick();
            bus.mem_ack_in = 1;
            tick();
            bus.mem_ack_in = 0;
            checks++;
            if (write_enable_out !== 1'b0 || bus.mem_req_out !== 1'b0 || stall_out !== 1'b0) begin
                failures++;
                $display("FAIL st_done got wen=%b req=%b stall=%b want 0 0 0", write_enable_out, bus.mem_req_out, stall_out);
            end
        end
    endtask

    task automatic test_timeout;
        valid_in = 1; mem_load_enable = 1; reg_write_enable = 1;
        alu_res = 32'h300; funct3 = 3'd2; rd_idx = 5'd9;
        tick();
        idle_in();
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (bus.mem_req_out !== 1'b1 || bus_err_out !== 1'b0) begin
                failures++;
                $display("FAIL tmo_early cycle=%0d got req=%b err=%b want req=1 err=0", k, bus.mem_req_out, bus_err_out);
            end
        end
        tick();
        checks++;
        if (bus.mem_req_out !== 1'b0 || bus_err_out !== 1'b1 || write_enable_out !== 1'b0 || stall_out !== 1'b0) begin
            failures++;
            $display("FAIL tmo_fire got req=%b err=%b wen=%b stall=%b want 0 1 0 0", bus.mem_req_out, bus_err_out, write_enable_out, stall_out);
        end
        tick();
        checks++;
        if (bus_err_out !== 1'b0) begin
            failures++;
            $display("FAIL tmo_pulse got err=%b want 0", bus_err_out);
        end
        valid_in = 1; mem_load_enable = 1; reg_write_enable = 1;
        tick();
        idle_in();
        repeat (3) tick();
        bus.mem_ack_in = 1;
        bus.mem_rdata_in = 32'h1122_3344;
        tick();
        bus.mem_ack_in = 0;
        checks++;
        if (bus_err_out !== 1'b0 || write_enable_out !== 1'b1 || write_data_out !== 32'h1122_3344) begin
            failures++;
            $display("FAIL ack_wins got err=%b wen=%b data=%h want err=0 wen=1 data=11223344", bus_err_out, write_enable_out, write_data_out);
        end
    endtask

    task automatic test_reset_mid_busy;
        valid_in = 1; mem_load_enable = 1; reg_write_enable = 1;
        alu_res = 32'h400; funct3 = 3'd2; rd_idx = 5'd3;
        tick();
        idle_in();
        tick();
        rst_n = 0;
        #1;
        checks++;
        if ({bus.mem_req_out, stall_out, write_enable_out, bus_err_out} !== 4'b0 || write_data_out !== 32'd0 || bus.mem_addr_out !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid got req=%b stall=%b wen=%b err=%b data=%h addr=%h want all zero", bus.mem_req_out, stall_out, write_enable_out, bus_err_out, write_data_out, bus.mem_addr_out);
        end
        #2;
        rst_n = 1;
        bus.mem_ack_in = 1;
        bus.mem_rdata_in = 32'hFFFF_FFFF;
        tick();
        bus.mem_ack_in = 0;
        checks++;
        if (write_enable_out !== 1'b0 || write_data_out !== 32'd0 || bus.mem_req_out !== 1'b0) begin
            failures++;
            $display("FAIL late_ack got wen=%b data=%h req=%b want 0 0 0", write_enable_out, write_data_out, bus.mem_req_out);
        end
    endtask

    task automatic test_illegal;
        logic [2:0] bad [3] = '{3'd3, 3'd6, 3'd7};
        for (int i = 0; i < 4; i++) begin
            valid_in = 1; reg_write_enable = 1; alu_res = 32'h500;
            if (i < 3) begin mem_load_enable = 1; funct3 = bad[i]; end
            else begin mem_store_enable = 1; funct3 = 3'd4; end
            tick();
            idle_in();
            checks++;
            if (bus.mem_req_out !== 1'b0 || bus_err_out !== 1'b1 || write_enable_out !== 1'b0) begin
                failures++;
                $display("FAIL illegal f3=%0d got req=%b err=%b wen=%b want 0 1 0", funct3, bus.mem_req_out, bus_err_out, write_enable_out);
            end
            tick();
            checks++;
            if (bus_err_out !== 1'b0 || bus.mem_req_out !== 1'b0) begin
                failures++;
                $display("FAIL illegal_pulse got err=%b req=%b want 0 0", bus_err_out, bus.mem_req_out);
            end
        end
    endtask

    task automatic test_misalign;
        valid_in = 1; mem_load_enable = 1; reg_write_enable = 1;
        alu_res = 32'h101; funct3 = 3'd2; rd_idx = 5'd11;
        tick();
        idle_in();
`ifdef STAGE4_MEM_MISALIGN_TRAP_EN
        checks++;
        if (bus.mem_req_out !== 1'b0 || bus_err_out !== 1'b1 || write_enable_out !== 1'b0) begin
            failures++;
            $display("FAIL misalign_trap got req=%b err=%b wen=%b want 0 1 0", bus.mem_req_out, bus_err_out, write_enable_out);
        end
`else
        checks++;
        if (bus.mem_req_out !== 1'b1 || bus.mem_addr_out !== 32'h100 || bus_err_out !== 1'b0) begin
            failures++;
            $display("FAIL misalign_req got req=%b addr=%h err=%b want req=1 addr=00000100 err=0", bus.mem_req_out, bus.mem_addr_out, bus_err_out);
        end
        bus.mem_ack_in = 1;
        bus.mem_rdata_in = 32'hCAFE_BABE;
        tick();
        bus.mem_ack_in = 0;
        checks++;
        if (write_enable_out !== 1'b1 || write_data_out !== exp_load(32'hCAFE_BABE, 32'h101, 3'd2) || bus_err_out !== 1'b0) begin
            failures++;
            $display("FAIL misalign_data got wen=%b data=%h err=%b want wen=1 data=%h err=0", write_enable_out, write_data_out, bus_err_out, exp_load(32'hCAFE_BABE, 32'h101, 3'd2));
        end
`endif
        tick();
    endtask

    initial begin
        bus.mem_ack_in = 0;
        bus.mem_rdata_in = 0;
        test_reset();
        test_passthrough();
        test_load();
        test_store();
        test_timeout();
        test_reset_mid_busy();
        test_illegal();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
